// File: rtl/out_fifo_sc.sv
`default_nettype none
// ============================================================================
// Module   : out_fifo_sc
// Purpose  : 8-entry single-clock transmit FIFO, 10 byte lanes in, 10 nibble
//            lanes out (low nibble first), with empty/full/almost flags.
// Revision : 1.0
// ============================================================================
module out_fifo_sc #(
    parameter ARRAY_MODE         = "ARRAY_MODE_8_X_4",
    parameter int ALMOST_EMPTY_VALUE = 1,
    parameter int ALMOST_FULL_VALUE  = 1,
    parameter int DEPTH              = 8
) (
    input  logic        CLK,
    input  logic        RESETB,
    input  logic        WREN,
    input  logic [79:0] D,
    input  logic        RDEN,
    output logic [39:0] Q,
    output logic        EMPTY,
    output logic        ALMOSTEMPTY,
    output logic        FULL,
    output logic        ALMOSTFULL,
    output logic        OVERFLOW,
    output logic        UNDERFLOW
);

    localparam int   LANES  = 10;
    localparam logic IS_8X4 = (ARRAY_MODE == "ARRAY_MODE_8_X_4");
    localparam logic PARAM_OK =
        ((ARRAY_MODE == "ARRAY_MODE_8_X_4") || (ARRAY_MODE == "ARRAY_MODE_4_X_4")) &&
        ((ALMOST_EMPTY_VALUE == 1) || (ALMOST_EMPTY_VALUE == 2)) &&
        ((ALMOST_FULL_VALUE == 1) || (ALMOST_FULL_VALUE == 2)) &&
        (DEPTH == 8);
    localparam logic [4:0] c_ae_value = 5'(ALMOST_EMPTY_VALUE);
    localparam logic [3:0] c_af_value = 4'(ALMOST_FULL_VALUE);

    generate
        if (!PARAM_OK) begin : g_param_check
`ifndef SYNTHESIS
            initial begin
                $display("Attribute Syntax Error : illegal parameter value on instance %m");
                $finish;
            end
`endif
        end
    endgenerate

    logic [79:0] mem [0:7];

    logic [2:0]  wptr_q, wptr_d;
    logic [2:0]  rptr_q, rptr_d;
    logic [3:0]  count_q, count_d;
    logic        phase_q, phase_d;
    logic [39:0] q_q, q_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    logic [4:0]  avail;
    logic [3:0]  free_entries;
    logic        empty, full;
    logic        do_wr, do_rd, frees;
    logic [79:0] rd_word;

    // In 8_X_4 mode each entry holds two readable nibble words
    assign avail        = IS_8X4 ? ({count_q, 1'b0} - {4'd0, phase_q}) : {1'b0, count_q};
    assign free_entries = 4'd8 - count_q;
    assign empty        = (avail == 5'd0);
    assign full         = (count_q == 4'd8);

    assign do_wr   = WREN & ~full;
    assign do_rd   = RDEN & ~empty;
    assign frees   = do_rd & (~IS_8X4 | phase_q);
    assign rd_word = mem[rptr_q];

    always_comb begin
        wptr_d  = wptr_q + {2'd0, do_wr};
        rptr_d  = rptr_q + {2'd0, frees};
        count_d = count_q + {3'd0, do_wr} - {3'd0, frees};
        phase_d = IS_8X4 ? (phase_q ^ do_rd) : 1'b0;
        ovf_d   = WREN & full;
        unf_d   = RDEN & empty;
        q_d     = q_q;
        if (do_rd) begin
            for (int n = 0; n < LANES; n++) begin
                q_d[4*n +: 4] = (IS_8X4 && phase_q) ? rd_word[8*n+4 +: 4]
                                                    : rd_word[8*n +: 4];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            wptr_q  <= 3'd0;
            rptr_q  <= 3'd0;
            count_q <= 4'd0;
            phase_q <= 1'b0;
            q_q     <= 40'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            phase_q <= phase_d;
            q_q     <= q_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem[wptr_q] <= D;
        end
    end

    assign Q           = q_q;
    assign EMPTY       = empty;
    assign ALMOSTEMPTY = (avail <= c_ae_value);
    assign FULL        = full;
    assign ALMOSTFULL  = (free_entries <= c_af_value);
    assign OVERFLOW    = ovf_q;
    assign UNDERFLOW   = unf_q;

endmodule
`default_nettype wire

// File: doc/out_fifo_sc.md
Name: out_fifo_sc

Overview:
Single-clock transmit-side FIFO for the 10-lane byte-lane datapath. Fabric writes one byte per lane per entry. The PHY side reads one nibble per lane per read, so the block performs 8-to-4 width reduction with the low nibble first. It mirrors the receive FIFO's 4-to-8 gathering, sits between fabric logic and the output serializers, and provides EMPTY, FULL and programmable almost-flags.

Parameters:
ARRAY_MODE, "ARRAY_MODE_8_X_4", width mode. "ARRAY_MODE_8_X_4" means each entry is drained in 2 nibble reads. "ARRAY_MODE_4_X_4" means 1 read per entry, and D bits [7:4] of each lane are ignored.
ALMOST_EMPTY_VALUE, 1, almost-empty threshold in readable words. Legal values are 1 and 2.
ALMOST_FULL_VALUE, 1, almost-full threshold in free entries. Legal values are 1 and 2.
DEPTH, 8, number of entries. Fixed at 8.
Illegal parameter values: print an "Attribute Syntax Error" with the instance path at time 0, then call $finish.

Ports:
CLK  input  1  Single clock for both write and read.
RESETB  input  1  Asynchronous active-low reset.
WREN  input  1  Write enable. Sampled on posedge CLK.
D  input  80  Write data. Lane n is D[8n+7:8n], for n = 0..9.
RDEN  input  1  Read enable. Sampled on posedge CLK.
Q  output  40  Read data. Lane n is Q[4n+3:4n]. Registered.
EMPTY  output  1  No readable word.
ALMOSTEMPTY  output  1  Readable words <= ALMOST_EMPTY_VALUE.
FULL  output  1  All 8 entries occupied.
ALMOSTFULL  output  1  Free entries <= ALMOST_FULL_VALUE.
OVERFLOW  output  1  One-cycle pulse: a write was attempted while FULL.
UNDERFLOW  output  1  One-cycle pulse: a read was attempted while EMPTY.

Behaviour:
- Reset: RESETB low clears all state immediately, without a clock. The state is wptr=0, rptr=0, count=0, phase=0, Q=0, EMPTY=1, ALMOSTEMPTY=1, FULL=0, ALMOSTFULL=0, OVERFLOW=0, UNDERFLOW=0. Storage array contents are not reset. Reset asserted mid-operation discards all queued data. The first write is accepted on the first posedge with RESETB high.
- State: 3-bit wptr, 3-bit rptr, 4-bit count (0..8 entries), 1-bit phase (nibble select, used in 8_X_4 mode only).
- Readable words: avail = 2*count - phase in 8_X_4 mode; avail = count in 4_X_4 mode.
- Flags are combinational decodes of registered state only, so they change the cycle after the causing edge:
  - EMPTY = (avail == 0).
  - ALMOSTEMPTY = (avail <= ALMOST_EMPTY_VALUE).
  - FULL = (count == 8).
  - ALMOSTFULL = (8 - count <= ALMOST_FULL_VALUE).
- Write: on posedge with WREN=1 and FULL=0, store D into mem[wptr] and increment wptr modulo 8 (wraps 7 to 0).
- Write while FULL: dropped, and OVERFLOW=1 for the next cycle. This holds even if the same edge performs a read.
- Read: on posedge with RDEN=1 and EMPTY=0, each lane's Q is updated.
  - 8_X_4 mode, phase=0: Q lane n <= mem[rptr] lane n bits [3:0], then phase <= 1.
  - 8_X_4 mode, phase=1: Q lane n <= bits [7:4], then phase <= 0, rptr increments modulo 8, and the entry is freed.
  - 4_X_4 mode: Q lane n <= bits [3:0], rptr increments, and the entry is freed.
- Read while EMPTY: Q holds its value, and UNDERFLOW=1 for the next cycle.
- Read latency: Q is valid on the cycle after the RDEN edge. A word written at edge k first shows EMPTY=0 after edge k, is readable at edge k+1, and appears on Q after edge k+1.
- Simultaneous write and read at the same edge, both legal: both occur.
  - count changes by +1 for the write and -1 for the read only if that read frees an entry. Net change is 0 when both happen.
  - Reads never return data written in the same edge.
- Q holds its last value whenever no read occurs.
- OVERFLOW and UNDERFLOW are registered single-cycle pulses and clear on the next edge without a fault.

Test Plan:
1. Reset mid-stream: write 3 entries, pulse RESETB low between edges -> immediately EMPTY=1, ALMOSTEMPTY=1, FULL=0, Q=0. A read after release gives UNDERFLOW=1 for 1 cycle.
2. 8_X_4 ordering: write lane0 = 0xA5, then 0x3C. Assert RDEN for 4 cycles -> Q lane0 = 5, A, C, 3. EMPTY=1 after the 4th read.
3. Fill and wrap: write 8 entries -> FULL=1 and ALMOSTFULL=1 after count=7 (ALMOST_FULL_VALUE=1). A 9th write gives OVERFLOW=1 and the data is dropped. Drain all, refill 8 -> wptr wraps and readback order is preserved.
4. Simultaneous: at count=4, WREN=1 with RDEN=1 for 10 cycles in 4_X_4 mode -> count stays 4, no flag toggles, Q sequence matches write order.
5. Almost-empty in 8_X_4 mode with ALMOST_EMPTY_VALUE=2: write 1 entry -> avail=2 and ALMOSTEMPTY=1. Write a 2nd entry -> avail=4 and ALMOSTEMPTY=0. Read twice -> ALMOSTEMPTY=1.
6. FULL priority: at FULL, same-edge WREN=1 and RDEN=1 -> OVERFLOW=1, count=8 still (8_X_4 first read only sets phase), write data is absent on later readback.
